// File: rtl/ca4_frame_ctrl_if.sv
// Bundle of the serial line plus the controller's observable outputs.
// The master modport is the frame controller; the slave side is the line driver / datapath.
interface ca4_frame_ctrl_if #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned CNT_W  = 4
);
    localparam int unsigned NREG = 2 ** ADDR_W;

    logic              serIn;
    logic              shData;
    logic [NREG-1:0]   ldReg;
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic              frameErr;
    logic [CNT_W-1:0]  frameCnt;

    modport master (
        input  serIn,
        output shData,
        output ldReg,
        output addr,
        output busy,
        output frameErr,
        output frameCnt
    );

    modport slave (
        output serIn,
        input  shData,
        input  ldReg,
        input  addr,
        input  busy,
        input  frameErr,
        input  frameCnt
    );
endinterface

// File: rtl/ca4_frame_ctrl.sv
// CA4 serial frame controller: start / address / data / stop framing, one-hot register load,
// framing-error pulse with line hunt, and a wrapping good-frame counter.
module ca4_frame_ctrl #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 4
) (
    input  logic CLK,
    input  logic RST,
    ca4_frame_ctrl_if.master bus
);
    localparam int unsigned NREG    = 2 ** ADDR_W;
    localparam int unsigned MaxLen  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned BitCntW = $clog2(MaxLen + 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StStop,
        StCommit,
        StErr,
        StHunt
    } state_e;

    state_e               state_q, state_d;
    logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [CNT_W-1:0]     frame_cnt_q;
    logic                 sh_data_q;
    logic [NREG-1:0]      ld_reg_q;
    logic                 busy_q;
    logic                 frame_err_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        unique case (state_q)
            StIdle: begin
                if (!bus.serIn) begin
                    state_d   = StAddr;
                    bit_cnt_d = '0;
                end
            end
            StAddr: begin
                addr_d = ADDR_W'({addr_q, bus.serIn});
                if (bit_cnt_q == BitCntW'(ADDR_W - 1)) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            StData: begin
                // Data bits go straight into the external shifter; only the count matters here.
                if (bit_cnt_q == BitCntW'(DATA_W - 1)) begin
                    state_d   = StStop;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            StStop:   state_d = bus.serIn ? StCommit : StErr;
            StCommit: state_d = StIdle;
            StErr:    state_d = StHunt;
            StHunt: begin
                if (bus.serIn) state_d = StIdle;
            end
            default:  state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they always match the current state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            addr_q      <= '0;
            frame_cnt_q <= '0;
            sh_data_q   <= 1'b0;
            ld_reg_q    <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            if (state_q == StCommit) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
            sh_data_q   <= (state_d == StData);
            ld_reg_q    <= (state_d == StCommit) ? (NREG'(1) << addr_d) : '0;
            busy_q      <= (state_d != StIdle);
            frame_err_q <= (state_d == StErr);
        end
    end

    assign bus.shData   = sh_data_q;
    assign bus.ldReg    = ld_reg_q;
    assign bus.addr     = addr_q;
    assign bus.busy     = busy_q;
    assign bus.frameErr = frame_err_q;
    assign bus.frameCnt = frame_cnt_q;
endmodule

// File: tb/tb_ca4_frame_ctrl.sv
// Directed bench for ca4_frame_ctrl with a small shift-register / L0..L3 datapath attached.
module tb_ca4_frame_ctrl;
    logic CLK;
    logic RST;
    int   tests;
    int   fails;

    ca4_frame_ctrl_if #(.ADDR_W(2), .CNT_W(4)) bus ();

    ca4_frame_ctrl #(
        .ADDR_W(2),
        .DATA_W(4),
        .CNT_W (4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // External datapath: not cleared by RST so loaded registers survive a controller reset.
    logic [3:0] sh_reg  = 4'h0;
    logic [3:0] lreg [4] = '{4'h0, 4'h0, 4'h0, 4'h0};

    always @(posedge CLK) begin
        if (bus.shData) sh_reg <= {sh_reg[2:0], bus.serIn};
        for (int i = 0; i < 4; i++) begin
            if (bus.ldReg[i]) lreg[i] <= sh_reg;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic s);
        bus.serIn = s;
        @(posedge CLK);
        #1;
    endtask

    // Sends start, address, data, stop; returns shData cycle count and outputs after the stop edge.
    task automatic send_frame(input logic [1:0] a, input logic [3:0] d, input logic stop_b,
                              output int shc, output logic [3:0] ld7, output logic err7);
        logic [7:0] bits;
        bits = {1'b0, a, d, stop_b};
        shc  = 0;
        for (int i = 7; i >= 0; i--) begin
            tick(bits[i]);
            if (bus.shData === 1'b1) shc++;
        end
        ld7  = bus.ldReg;
        err7 = bus.frameErr;
    endtask

    initial begin
        int         shc;
        logic [3:0] ld7;
        logic       err7;
        logic [3:0] ld_tab [4];
        logic [3:0] d_tab  [4];

        ld_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        d_tab  = '{4'h1, 4'h2, 4'h3, 4'h4};
        tests = 0;
        fails = 0;
        bus.serIn = 1'b1;

        // Reset with the line toggling
        RST = 1'b1;
        tick(1'b0);
        tick(1'b1);
        chk("rst_shData", 32'(bus.shData), 0);
        chk("rst_ldReg", 32'(bus.ldReg), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_frameErr", 32'(bus.frameErr), 0);
        chk("rst_frameCnt", 32'(bus.frameCnt), 0);
        chk("rst_addr", 32'(bus.addr), 0);
        RST = 1'b0;
        tick(1'b1);
        chk("idle_busy", 32'(bus.busy), 0);

        // Good frame: 0,1,0,1,0,1,1,1
        send_frame(2'b10, 4'b1011, 1'b1, shc, ld7, err7);
        chk("good_ldReg", 32'(ld7), 32'h4);
        chk("good_err", 32'(err7), 0);
        chk("good_shcnt", 32'(shc), 4);
        chk("good_addr", 32'(bus.addr), 32'h2);
        chk("good_busy", 32'(bus.busy), 1);
        tick(1'b1);
        chk("good_ld_off", 32'(bus.ldReg), 0);
        chk("good_cnt", 32'(bus.frameCnt), 1);
        chk("good_idle", 32'(bus.busy), 0);
        chk("good_L2", 32'(lreg[2]), 32'hB);
        chk("good_L0", 32'(lreg[0]), 0);
        chk("good_L1", 32'(lreg[1]), 0);
        chk("good_L3", 32'(lreg[3]), 0);

        // Bad stop bit: 0,0,1,1,1,1,1,0 then 0,0,1
        send_frame(2'b01, 4'b1111, 1'b0, shc, ld7, err7);
        chk("bad_err", 32'(err7), 1);
        chk("bad_ldReg", 32'(ld7), 0);
        tick(1'b0);
        chk("bad_err_pulse", 32'(bus.frameErr), 0);
        chk("bad_hunt1", 32'(bus.busy), 1);
        tick(1'b0);
        chk("bad_hunt2", 32'(bus.busy), 1);
        tick(1'b1);
        chk("bad_idle", 32'(bus.busy), 0);
        chk("bad_cnt", 32'(bus.frameCnt), 1);
        chk("bad_L1", 32'(lreg[1]), 0);

        // Back-to-back frames at minimum spacing
        for (int k = 0; k < 4; k++) begin
            send_frame(2'(k), d_tab[k], 1'b1, shc, ld7, err7);
            chk($sformatf("b2b_ld%0d", k), 32'(ld7), 32'(ld_tab[k]));
            tick(1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("b2b_L%0d", k), 32'(lreg[k]), 32'(d_tab[k]));
        end
        chk("b2b_cnt", 32'(bus.frameCnt), 5);

        // Reset at E4 of a frame addressed 10, data 0111
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        RST = 1'b1;
        tick(1'b1);
        RST = 1'b0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_addr", 32'(bus.addr), 0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b1);
            chk($sformatf("abort_ld%0d", k), 32'(bus.ldReg), 0);
            chk($sformatf("abort_busy%0d", k), 32'(bus.busy), 0);
        end
        chk("abort_cnt", 32'(bus.frameCnt), 0);
        chk("abort_L2", 32'(lreg[2]), 32'h3);
        send_frame(2'b11, 4'h9, 1'b1, shc, ld7, err7);
        chk("post_abort_ld", 32'(ld7), 32'h8);
        tick(1'b1);
        chk("post_abort_cnt", 32'(bus.frameCnt), 1);
        chk("post_abort_L3", 32'(lreg[3]), 32'h9);

        // Counter wrap: 15 more frames bring the count from 1 around to 0
        for (int k = 0; k < 15; k++) begin
            send_frame(2'(k), 4'(k), 1'b1, shc, ld7, err7);
            tick(1'b1);
            if (k == 13) chk("wrap_cnt15", 32'(bus.frameCnt), 15);
        end
        chk("wrap_cnt0", 32'(bus.frameCnt), 0);

        // Idle line keeps the controller quiet
        for (int k = 0; k < 20; k++) begin
            tick(1'b1);
            chk($sformatf("idle_busy%0d", k), 32'(bus.busy), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
